uart_tx_engine: RTL and testbench

- Standalone UART transmitter that serialises one user byte per valid/ready handshake onto the tx line.
- Supports configurable data width, parity (none, odd or even) and 1 or 2 stop bits.
- It is the transmit half paired with the existing receive path inside uart_drive. It sits between the loopback FIFO read logic and the o_uart_tx pin, and uses the same user-side handshake names.

---
 rtl/uart_tx_engine.sv | 157 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// Purpose : UART transmitter that serialises one user word per valid/ready handshake
//           onto o_uart_tx: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Latency : start bit is on the line the clock after the handshake edge; every line bit
//           lasts DIV = P_SYSTEM_CLK / P_UART_BUADRATE clocks.
// Backpressure: o_user_tx_ready is low for the whole frame and valid is ignored then.
//           Nothing is queued, so the upstream holds or re-issues the word.
// Ports   : i_clk, i_rst (async, active-high), i_user_tx_data/i_user_tx_valid/
//           o_user_tx_ready (user handshake), o_uart_tx (registered serial line, idles high).
module uart_tx_engine #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx
);

  localparam int DIV = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW  = P_UART_DATA_WIDTH;

  // Unsupported configurations are rejected at elaboration.
  generate
    if (DW < 5 || DW > 8) begin : g_bad_dw
      $error("uart_tx_engine: P_UART_DATA_WIDTH must be 5..8");
    end
    if (P_UART_STOP_WIDTH != 1 && P_UART_STOP_WIDTH != 2) begin : g_bad_stop
      $error("uart_tx_engine: P_UART_STOP_WIDTH must be 1 or 2");
    end
    if (P_UART_CHECK < 0 || P_UART_CHECK > 2) begin : g_bad_check
      $error("uart_tx_engine: P_UART_CHECK must be 0, 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_engine: P_SYSTEM_CLK / P_UART_BUADRATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [DW-1:0]   shift_q;
  logic            par_q;
  logic            tx_q;
  logic            rdy_q;
  logic            bit_end;

  // Last clock of the current line bit; every state change happens on this edge.
  assign bit_end = (baud_q == CW'(DIV - 1));

  assign o_uart_tx       = tx_q;
  assign o_user_tx_ready = rdy_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      // Baud counter only runs while a frame is in flight.
      if (state_q == S_IDLE || bit_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (rdy_q && i_user_tx_valid) begin
            shift_q <= i_user_tx_data;
            // Parity is fixed at acceptance so later input changes cannot leak in.
            par_q   <= (P_UART_CHECK == 1) ? ~(^i_user_tx_data) : (^i_user_tx_data);
            rdy_q   <= 1'b0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end else begin
            // Also raises ready on the first edge after reset release.
            rdy_q <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[DW-1:1]};
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'(DW - 1)) begin
              bit_q <= '0;
              if (P_UART_CHECK != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[DW-1:1]};
              bit_q   <= bit_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            bit_q   <= '0;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (bit_q == 3'(P_UART_STOP_WIDTH - 1)) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: five instances (8N1, 8E1, 8O1, 8N2, 5O2) at DIV=10,
// every line clock compared against a frame model built from the framing rules.
module tb_uart_tx_engine;

  localparam int DIV = 10;
  localparam int DW_C [5] = '{8, 8, 8, 8, 5};
  localparam int CK_C [5] = '{0, 2, 1, 0, 1};
  localparam int SP_C [5] = '{1, 1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_r [5];
  logic [4:0] valid_r;
  logic [4:0] tx_w;
  logic [4:0] rdy_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000),
                   .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_r[0]), .i_user_tx_valid(valid_r[0]),
    .o_user_tx_ready(rdy_w[0]), .o_uart_tx(tx_w[0]));

  uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000),
                   .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_r[1]), .i_user_tx_valid(valid_r[1]),
    .o_user_tx_ready(rdy_w[1]), .o_uart_tx(tx_w[1]));

  uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000),
                   .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_8o1 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_r[2]), .i_user_tx_valid(valid_r[2]),
    .o_user_tx_ready(rdy_w[2]), .o_uart_tx(tx_w[2]));

  uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000),
                   .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) u_8n2 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_r[3]), .i_user_tx_valid(valid_r[3]),
    .o_user_tx_ready(rdy_w[3]), .o_uart_tx(tx_w[3]));

  uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000),
                   .P_UART_DATA_WIDTH(5), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(1)) u_5o2 (
    .i_clk(clk), .i_rst(rst), .i_user_tx_data(data_r[4][4:0]), .i_user_tx_valid(valid_r[4]),
    .o_user_tx_ready(rdy_w[4]), .o_uart_tx(tx_w[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame length in line bits for instance d.
  function automatic int frame_slots(input int d);
    return 1 + DW_C[d] + ((CK_C[d] != 0) ? 1 : 0) + SP_C[d];
  endfunction

  // Expected line level during bit slot 'slot' of a frame carrying b on instance d.
  function automatic logic exp_bit(input int d, input logic [7:0] b, input int slot);
    int ones = 0;
    for (int k = 0; k < DW_C[d]; k++) ones += int'(b[k]);
    if (slot == 0) return 1'b0;
    if (slot <= DW_C[d]) return b[slot-1];
    if (CK_C[d] != 0 && slot == DW_C[d] + 1) begin
      // ODD: data+parity carries an odd number of ones; EVEN: an even number.
      if (CK_C[d] == 1) return ((ones % 2) == 0);
      return ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  // Bounded wait for ready, then a one-edge valid pulse; returns #1 after the handshake edge.
  task automatic handshake(input int d, input logic [7:0] b);
    int n = 0;
    while (rdy_w[d] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk($sformatf("ready_timeout_d%0d", d), 32'(rdy_w[d]), 32'd1);
    data_r[d]  = b;
    valid_r[d] = 1'b1;
    @(posedge clk); #1;
    valid_r[d] = 1'b0;
  endtask

  // Called #1 after the handshake edge: checks line and ready on every clock of the frame,
  // then ready high and line idle on the clock after. inj>=0 pulses valid with 0x77 mid-frame.
  task automatic check_frame(input int d, input logic [7:0] b, input int inj, input bit scramble);
    int len = frame_slots(d) * DIV;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("line_d%0d_b%02h_clk%0d", d, b, i), 32'(tx_w[d]), 32'(exp_bit(d, b, i / DIV)));
      chk($sformatf("rdy_low_d%0d_b%02h_clk%0d", d, b, i), 32'(rdy_w[d]), 32'd0);
      if (scramble) data_r[d] = 8'($urandom);
      if (i == inj) begin
        valid_r[d] = 1'b1;
        data_r[d]  = 8'h77;
      end else if (inj >= 0 && i == inj + 1) begin
        valid_r[d] = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (inj >= 0) valid_r[d] = 1'b0;
    chk($sformatf("rdy_back_d%0d_b%02h", d, b), 32'(rdy_w[d]), 32'd1);
    chk($sformatf("idle_line_d%0d_b%02h", d, b), 32'(tx_w[d]), 32'd1);
  endtask

  initial begin
    logic [7:0] rb;
    int         rd;
    int         rinj;

    rst     = 1'b1;
    valid_r = '0;
    for (int d = 0; d < 5; d++) data_r[d] = 8'h00;

    // Reset values while reset is held.
    #1;
    for (int d = 0; d < 5; d++) begin
      chk($sformatf("rst_tx_d%0d", d), 32'(tx_w[d]), 32'd1);
      chk($sformatf("rst_rdy_d%0d", d), 32'(rdy_w[d]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rdy_before_first_edge", 32'(rdy_w[0]), 32'd0);
    @(posedge clk); #1;
    for (int d = 0; d < 5; d++) begin
      chk($sformatf("rdy_first_edge_d%0d", d), 32'(rdy_w[d]), 32'd1);
      chk($sformatf("tx_idle_d%0d", d), 32'(tx_w[d]), 32'd1);
    end

    // Directed frames: 8N1, even/odd parity, 8N2, 5-bit odd 2-stop.
    handshake(0, 8'hA5); check_frame(0, 8'hA5, -1, 1'b1);
    handshake(1, 8'hA5); check_frame(1, 8'hA5, -1, 1'b1);
    handshake(2, 8'hA5); check_frame(2, 8'hA5, -1, 1'b1);
    handshake(1, 8'h01); check_frame(1, 8'h01, -1, 1'b1);
    handshake(3, 8'hFF); check_frame(3, 8'hFF, -1, 1'b1);
    handshake(4, 8'h15); check_frame(4, 8'h15, -1, 1'b1);

    // Back-to-back with valid held high: 0x55 then 0x33, one idle clock between.
    handshake(0, 8'h55);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h33;
    check_frame(0, 8'h55, -1, 1'b0);
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    check_frame(0, 8'h33, -1, 1'b1);

    // Valid pulse of 0x77 mid-frame must never be sent.
    handshake(0, 8'h5A);
    check_frame(0, 8'h5A, 35, 1'b1);
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("no_dropped_frame_clk%0d", i), 32'(tx_w[0]), 32'd1);
      @(posedge clk); #1;
    end

    // Reset during data bit 3 of 0xA5, then a clean 0x3C frame.
    handshake(0, 8'hA5);
    for (int i = 0; i < 45; i++) begin
      chk($sformatf("pre_rst_line_clk%0d", i), 32'(tx_w[0]), 32'(exp_bit(0, 8'hA5, i / DIV)));
      @(posedge clk); #1;
    end
    chk("bit3_low_before_rst", 32'(tx_w[0]), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_mid_rdy", 32'(rdy_w[0]), 32'd0);
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_mid_rst", 32'(rdy_w[0]), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("no_resume_clk%0d", i), 32'(tx_w[0]), 32'd1);
      @(posedge clk); #1;
    end
    handshake(0, 8'h3C); check_frame(0, 8'h3C, -1, 1'b1);

    // Random frames over random instances, some with a stray mid-frame valid.
    for (int n = 0; n < 12; n++) begin
      rd   = int'($urandom_range(0, 4));
      rb   = 8'($urandom);
      if (rd == 4) rb[7:5] = 3'b000;
      rinj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, frame_slots(rd) * DIV - 1)) : -1;
      handshake(rd, rb);
      check_frame(rd, rb, rinj, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
